gate_operand_feeder: RTL and testbench

GATE_OPERAND_FEEDER -- requirements
Module: gate_operand_feeder

---
 rtl/gate_operand_feeder_pkg.sv | 38 +++
 rtl/vec_pingpong.sv | 39 +++
 rtl/gate_operand_feeder.sv | 205 ++++++++++++++++++++
 tb/tb_gate_operand_feeder.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_operand_feeder_pkg.sv
// gate_operand_feeder_pkg
//   Shared definitions for the gate operand feeder:
//   - width derivations for Q(QN.QM) fixed-point words and whole weight columns
//   - log2 helper used to size address ports
//   - FSM state encoding
package gate_operand_feeder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        BUSY = 2'd2
    } fsm_state_t;

    // One signed fixed-point word: sign + QN integer bits + QM fraction bits.
    function automatic int calc_bitwidth(input int qn, input int qm);
        return qn + qm + 1;
    endfunction

    // One weight column holds one word per gate row.
    function automatic int calc_layer_bitwidth(input int qn, input int qm, input int hidden_sz);
        return calc_bitwidth(qn, qm) * hidden_sz;
    endfunction

    // Number of bits needed to represent 'value' itself (minimum 1).
    // Sizing the address by INPUT_SZ rather than INPUT_SZ-1 leaves headroom
    // so out-of-range indices can reach the block and be flagged.
    function automatic int log2(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((value >> i) != 0) begin
                w = i + 1;
            end
        end
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/vec_pingpong.sv
// vec_pingpong
//   Two banks of DEPTH x WIDTH storage for x vectors. One bank is filled
//   while the other is read; the caller chooses both bank selects.
//   Storage is not reset.
// Ports:
//   clk      in   clock
//   wr_en    in   write strobe (caller has already range-checked wr_idx)
//   wr_bank  in   bank written
//   wr_idx   in   element index written
//   wr_data  in   element data
//   rd_bank  in   bank read
//   rd_idx   in   element index read
//   rd_data  out  combinational read data
module vec_pingpong #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 18,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic             wr_bank,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_bank,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_q [2][DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_bank][wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_bank][rd_idx];

endmodule

// File: rtl/gate_operand_feeder.sv
// gate_operand_feeder
//   Holds the weight columns and a double-buffered x vector for one LSTM
//   gate, and starts the gate whenever a committed x vector is available.
//   A committed write bank is swapped into the read side, beginCalc pulses,
//   and the block stays busy until the gate reports done. A vector committed
//   during a calculation is started back-to-back when the gate finishes.
// Ports:
//   clock, reset      rising-edge clock, synchronous active-low reset
//   loadValid/Ready   write handshake: a write is accepted when both are 1
//   loadSel           0 = weight column, 1 = x element
//   loadAddr          column / element index
//   loadData          column data (x writes use the low BITWIDTH bits)
//   loadCommit        marks the write bank as a complete x vector
//   commitReady       1 while the write bank can still be committed
//   colAddress_X      read address from the gate
//   weightMem_X       registered weight column read
//   inputVec          registered x element read
//   beginCalc         one-cycle start pulse
//   dataReady_gate    gate-done pulse (only honoured while BUSY)
//   busy              calculation outstanding
//   overflowErr       sticky: dropped commit or out-of-range write
//   dbg_state         FSM state
//   dbg_rd_bank       bank currently serving reads
module gate_operand_feeder
    import gate_operand_feeder_pkg::*;
#(
    parameter int INPUT_SZ  = 8,
    parameter int HIDDEN_SZ = 64,
    parameter int QN        = 6,
    parameter int QM        = 11,
    localparam int BITWIDTH        = calc_bitwidth(QN, QM),
    localparam int LAYER_BITWIDTH  = calc_layer_bitwidth(QN, QM, HIDDEN_SZ),
    localparam int ADDR_BITWIDTH_X = log2(INPUT_SZ)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       loadValid,
    output logic                       loadReady,
    input  logic                       loadSel,
    input  logic [ADDR_BITWIDTH_X-1:0] loadAddr,
    input  logic [LAYER_BITWIDTH-1:0]  loadData,
    input  logic                       loadCommit,
    output logic                       commitReady,
    input  logic [ADDR_BITWIDTH_X-1:0] colAddress_X,
    output logic [LAYER_BITWIDTH-1:0]  weightMem_X,
    output logic [BITWIDTH-1:0]        inputVec,
    output logic                       beginCalc,
    input  logic                       dataReady_gate,
    output logic                       busy,
    output logic                       overflowErr,
    output logic [1:0]                 dbg_state,
    output logic                       dbg_rd_bank
);

    // Index width into the storage arrays (address port carries one extra bit).
    localparam int IDX_W = log2(INPUT_SZ - 1);
    localparam logic [ADDR_BITWIDTH_X-1:0] LAST_ADDR = ADDR_BITWIDTH_X'(INPUT_SZ - 1);

    fsm_state_t state_q, state_d;
    logic rd_bank_q, rd_bank_d;
    logic wr_bank_full_q, wr_bank_full_d;
    logic begin_calc_q, begin_calc_d;
    logic overflow_err_q, overflow_err_d;
    logic [LAYER_BITWIDTH-1:0] weight_mem_x_q, weight_mem_x_d;
    logic [BITWIDTH-1:0] input_vec_q, input_vec_d;

    logic [LAYER_BITWIDTH-1:0] weight_mem_q [INPUT_SZ];

    logic load_in_range, rd_in_range;
    logic load_ready, load_fire, x_we, w_we;
    logic [IDX_W-1:0] load_idx, rd_idx;
    logic [BITWIDTH-1:0] x_rd_data;

    assign load_idx = loadAddr[IDX_W-1:0];
    assign rd_idx   = colAddress_X[IDX_W-1:0];

    always_comb begin
        load_in_range = (loadAddr <= LAST_ADDR);
        rd_in_range   = (colAddress_X <= LAST_ADDR);
        // x writes only need a free write bank; weight writes are also locked
        // out while a calculation is armed or running.
        if (loadSel) begin
            load_ready = !wr_bank_full_q;
        end else begin
            load_ready = (state_q == IDLE) && !wr_bank_full_q;
        end
        load_fire = loadValid && load_ready;
        x_we      = load_fire && loadSel && load_in_range;
        w_we      = load_fire && !loadSel && load_in_range;
    end

    // Control: commit bookkeeping plus IDLE/ARM/BUSY sequencing.
    // Commit needs !wr_bank_full_q and a swap needs wr_bank_full_q, so the
    // two updates to wr_bank_full_d below can never collide.
    always_comb begin
        state_d        = state_q;
        rd_bank_d      = rd_bank_q;
        wr_bank_full_d = wr_bank_full_q;
        overflow_err_d = overflow_err_q;

        if (loadCommit) begin
            if (!wr_bank_full_q) begin
                wr_bank_full_d = 1'b1;
            end else begin
                overflow_err_d = 1'b1;
            end
        end
        if (load_fire && !load_in_range) begin
            overflow_err_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (wr_bank_full_q) begin
                    rd_bank_d      = !rd_bank_q;
                    wr_bank_full_d = 1'b0;
                    state_d        = ARM;
                end
            end
            ARM: begin
                state_d = BUSY;
            end
            BUSY: begin
                if (dataReady_gate) begin
                    if (wr_bank_full_q) begin
                        rd_bank_d      = !rd_bank_q;
                        wr_bank_full_d = 1'b0;
                        state_d        = ARM;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Registered so the pulse coincides exactly with the ARM state.
        begin_calc_d = (state_d == ARM);
    end

    // Read path: out-of-range addresses return zeros.
    always_comb begin
        weight_mem_x_d = '0;
        input_vec_d    = '0;
        if (rd_in_range) begin
            weight_mem_x_d = weight_mem_q[rd_idx];
            input_vec_d    = x_rd_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q        <= IDLE;
            rd_bank_q      <= 1'b0;
            wr_bank_full_q <= 1'b0;
            begin_calc_q   <= 1'b0;
            overflow_err_q <= 1'b0;
            weight_mem_x_q <= '0;
            input_vec_q    <= '0;
        end else begin
            state_q        <= state_d;
            rd_bank_q      <= rd_bank_d;
            wr_bank_full_q <= wr_bank_full_d;
            begin_calc_q   <= begin_calc_d;
            overflow_err_q <= overflow_err_d;
            weight_mem_x_q <= weight_mem_x_d;
            input_vec_q    <= input_vec_d;
        end
    end

    // Weight storage, deliberately not reset.
    always_ff @(posedge clock) begin
        if (w_we) begin
            weight_mem_q[load_idx] <= loadData;
        end
    end

    vec_pingpong #(
        .DEPTH (INPUT_SZ),
        .WIDTH (BITWIDTH),
        .IDX_W (IDX_W)
    ) u_x_store (
        .clk     (clock),
        .wr_en   (x_we),
        .wr_bank (!rd_bank_q),
        .wr_idx  (load_idx),
        .wr_data (loadData[BITWIDTH-1:0]),
        .rd_bank (rd_bank_q),
        .rd_idx  (rd_idx),
        .rd_data (x_rd_data)
    );

    assign loadReady   = load_ready;
    assign commitReady = !wr_bank_full_q;
    assign weightMem_X = weight_mem_x_q;
    assign inputVec    = input_vec_q;
    assign beginCalc   = begin_calc_q;
    assign busy        = (state_q != IDLE);
    assign overflowErr = overflow_err_q;
    assign dbg_state   = state_q;
    assign dbg_rd_bank = rd_bank_q;

endmodule

// File: tb/tb_gate_operand_feeder.sv
// tb_gate_operand_feeder
//   Directed bench for gate_operand_feeder with INPUT_SZ=8, HIDDEN_SZ=4,
//   QN=6, QM=11 (BITWIDTH=18, LAYER_BITWIDTH=72, 4-bit addresses).
module tb_gate_operand_feeder;

    localparam int INPUT_SZ  = 8;
    localparam int HIDDEN_SZ = 4;
    localparam int QN        = 6;
    localparam int QM        = 11;
    localparam int BW        = 18;
    localparam int LBW       = 72;
    localparam int AW        = 4;

    // clock / reset
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic           reset;
    logic           loadValid;
    logic           loadReady;
    logic           loadSel;
    logic [AW-1:0]  loadAddr;
    logic [LBW-1:0] loadData;
    logic           loadCommit;
    logic           commitReady;
    logic [AW-1:0]  colAddress_X;
    logic [LBW-1:0] weightMem_X;
    logic [BW-1:0]  inputVec;
    logic           beginCalc;
    logic           dataReady_gate;
    logic           busy;
    logic           overflowErr;
    logic [1:0]     dbg_state;
    logic           dbg_rd_bank;

    gate_operand_feeder #(
        .INPUT_SZ  (INPUT_SZ),
        .HIDDEN_SZ (HIDDEN_SZ),
        .QN        (QN),
        .QM        (QM)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .loadValid      (loadValid),
        .loadReady      (loadReady),
        .loadSel        (loadSel),
        .loadAddr       (loadAddr),
        .loadData       (loadData),
        .loadCommit     (loadCommit),
        .commitReady    (commitReady),
        .colAddress_X   (colAddress_X),
        .weightMem_X    (weightMem_X),
        .inputVec       (inputVec),
        .beginCalc      (beginCalc),
        .dataReady_gate (dataReady_gate),
        .busy           (busy),
        .overflowErr    (overflowErr),
        .dbg_state      (dbg_state),
        .dbg_rd_bank    (dbg_rd_bank)
    );

    // scoreboard
    int n_checks = 0;
    int n_errors = 0;
    logic [LBW-1:0] exp_q[$];
    int begin_seen;

    task automatic check(input string tag, input logic [LBW-1:0] got, input logic [LBW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // driver tasks: all inputs change 1 time unit after a rising edge
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic write_w(input int col, input logic [LBW-1:0] data);
        loadValid = 1'b1;
        loadSel   = 1'b0;
        loadAddr  = AW'(col);
        loadData  = data;
        step();
        loadValid = 1'b0;
    endtask

    task automatic write_x(input int idx, input int val);
        loadValid = 1'b1;
        loadSel   = 1'b1;
        loadAddr  = AW'(idx);
        loadData  = LBW'(val);
        step();
        loadValid = 1'b0;
    endtask

    task automatic commit();
        loadCommit = 1'b1;
        step();
        loadCommit = 1'b0;
    endtask

    task automatic gate_done();
        dataReady_gate = 1'b1;
        step();
        dataReady_gate = 1'b0;
    endtask

    task automatic read(input int addr);
        colAddress_X = AW'(addr);
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b0;
        loadValid      = 1'b0;
        loadSel        = 1'b0;
        loadAddr       = '0;
        loadData       = '0;
        loadCommit     = 1'b0;
        colAddress_X   = '0;
        dataReady_gate = 1'b0;
        step();
        step();

        // reset state
        check("rst_busy", busy, 0);
        check("rst_begin", beginCalc, 0);
        check("rst_ovf", overflowErr, 0);
        check("rst_weight", weightMem_X, 0);
        check("rst_input", inputVec, 0);
        check("rst_commit_ready", commitReady, 1);
        check("rst_rd_bank", dbg_rd_bank, 0);
        check("rst_state", dbg_state, 0);
        reset = 1'b1;

        // first vector: weights col*0x1000, x = 1..8 into bank 1
        for (int c = 0; c < INPUT_SZ; c++) write_w(c, LBW'(c) * LBW'('h1000));
        for (int c = 0; c < INPUT_SZ; c++) write_x(c, c + 1);
        check("pre_commit_ready", commitReady, 1);
        commit();
        check("commit_ready_low", commitReady, 0);
        check("begin_early", beginCalc, 0);
        step();
        check("begin_2cyc", beginCalc, 1);
        check("busy_arm", busy, 1);
        check("rd_bank_swap1", dbg_rd_bank, 1);
        step();
        check("begin_one_cycle", beginCalc, 0);
        check("state_busy", dbg_state, 2);
        read(3);
        check("w_col3", weightMem_X, 72'h3000);
        check("x_col3", inputVec, 4);
        for (int c = 0; c < INPUT_SZ; c++) begin
            exp_q.push_back(LBW'(c + 1));
            read(c);
            check("x_sweep", inputVec, exp_q.pop_front());
        end

        // weight write while BUSY is refused
        loadValid = 1'b1;
        loadSel   = 1'b0;
        loadAddr  = 4'd2;
        loadData  = 72'hDEAD;
        #1;
        check("w_ready_busy", loadReady, 0);
        step();
        loadValid = 1'b0;

        // second vector 9..16 into bank 0 during BUSY
        loadValid = 1'b1;
        loadSel   = 1'b1;
        loadAddr  = 4'd0;
        loadData  = 72'd9;
        #1;
        check("x_ready_busy", loadReady, 1);
        step();
        loadValid = 1'b0;
        for (int c = 1; c < INPUT_SZ; c++) write_x(c, c + 9);
        commit();
        check("commit_ready_busy", commitReady, 0);
        gate_done();
        check("b2b_begin", beginCalc, 1);
        check("b2b_state_arm", dbg_state, 1);
        check("rd_bank_swap2", dbg_rd_bank, 0);
        read(0);
        check("b2b_x0", inputVec, 9);
        check("b2b_state_busy", dbg_state, 2);

        // double commit while a vector is pending
        commit();
        check("commit_full", commitReady, 0);
        check("ovf_before", overflowErr, 0);
        loadValid = 1'b1;
        loadSel   = 1'b1;
        loadAddr  = 4'd0;
        loadData  = 72'd99;
        #1;
        check("x_ready_full", loadReady, 0);
        step();
        loadValid = 1'b0;
        commit();
        check("ovf_third_commit", overflowErr, 1);
        gate_done();
        check("rd_bank_swap3", dbg_rd_bank, 1);
        read(0);
        check("bank_unchanged", inputVec, 1);
        gate_done();
        check("idle_busy", busy, 0);
        check("idle_state", dbg_state, 0);
        read(2);
        check("w_col2_unchanged", weightMem_X, 72'h2000);
        loadSel = 1'b0;
        #1;
        check("w_ready_idle", loadReady, 1);

        // reset clears sticky error, then out-of-range cases
        reset = 1'b0;
        step();
        reset = 1'b1;
        check("ovf_cleared", overflowErr, 0);
        check("rst2_rd_bank", dbg_rd_bank, 0);
        read(1);
        check("w_col1", weightMem_X, 72'h1000);
        check("x_bank0_1", inputVec, 10);
        read(8);
        check("w_oor8", weightMem_X, 0);
        check("x_oor8", inputVec, 0);
        read(15);
        check("w_oor15", weightMem_X, 0);
        write_w(9, 72'hBAD);
        check("ovf_oor_write", overflowErr, 1);
        read(1);
        check("w_col1_discard", weightMem_X, 72'h1000);

        // reset mid-BUSY
        commit();
        step();
        step();
        check("pre_rst_busy", busy, 1);
        check("pre_rst_bank", dbg_rd_bank, 1);
        reset = 1'b0;
        step();
        reset = 1'b1;
        check("midrst_busy", busy, 0);
        check("midrst_bank", dbg_rd_bank, 0);
        check("midrst_ovf", overflowErr, 0);
        begin_seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (beginCalc) begin_seen++;
            step();
        end
        check("midrst_no_begin", LBW'(begin_seen), 0);
        check("midrst_idle", dbg_state, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
